// File: rtl/i2c_target_responder.sv
// i2c_target_responder
//   I2C target that stands in for a TMP101-style temperature sensor. SCL and
//   SDA are oversampled on the system clock. The block decodes START/STOP,
//   the address and the R/W bit, ACKs, and moves register bytes over an
//   open-drain SDA.
//
// Ports
//   clock       system clock, at least 8x the SCL rate
//   Reset       asynchronous active-low reset
//   SCL         bus clock from the master (asynchronous to clock)
//   SDA         open-drain data; this block drives only 0 or z
//   TempIn      live 12-bit two's complement temperature code
//   ConfigOut   configuration register (pointer 1)
//   TLowOut     TLOW register (pointer 2)
//   THighOut    THIGH register (pointer 3)
//   Selected    high from address-match ACK until STOP, repeated START or master NACK
//   WriteStrobe one-cycle pulse when a register is updated
module i2c_target_responder #(
    parameter logic [6:0]  SLAVE_ADDR  = 7'b1001000,
    parameter logic [15:0] TLOW_RESET  = 16'h4B00,
    parameter logic [15:0] THIGH_RESET = 16'h5000
) (
    input  logic        clock,
    input  logic        Reset,
    input  logic        SCL,
    inout  wire         SDA,
    input  logic [11:0] TempIn,
    output logic [7:0]  ConfigOut,
    output logic [15:0] TLowOut,
    output logic [15:0] THighOut,
    output logic        Selected,
    output logic        WriteStrobe
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RD_ACK, IGNORE
    } stateT;

    stateT       state, stateNxt;
    logic        sclS1, sclS2, sclPrev;
    logic        sdaS1, sdaS2, sdaPrev;
    logic [7:0]  shReg, shNxt;
    logic [3:0]  bitCnt, cntNxt;
    logic [1:0]  byteIdx, idxNxt;
    logic [1:0]  ptr, ptrNxt;
    logic [15:0] tempSnap, snapNxt;
    logic [7:0]  stage, stageNxt;
    logic [7:0]  configReg, cfgNxt;
    logic [15:0] tLowReg, tLowNxt;
    logic [15:0] tHighReg, tHighNxt;
    logic        sdaLow, sdaLowNxt;
    logic        selReg, selNxt;
    logic        strobe, strobeNxt;

    logic        sclRise, sclFall, startCond, stopCond;
    logic [1:0]  nextIdx;
    logic [7:0]  curByte, msbByte, nextByte;

    // Open drain: never drive a 1.
    assign SDA = sdaLow ? 1'b0 : 1'bz;

    assign sclRise   =  sclS2 & ~sclPrev;
    assign sclFall   = ~sclS2 &  sclPrev;
    assign startCond =  sclS2 & sclPrev &  sdaPrev & ~sdaS2;
    assign stopCond  =  sclS2 & sclPrev & ~sdaPrev &  sdaS2;

    // Byte presented on a read; idx 0 is the MSB. Config is a single byte,
    // so it appears in both halves.
    function automatic logic [7:0] rdByte(input logic [1:0] p, input logic idx,
                                          input logic [15:0] t, input logic [7:0] c,
                                          input logic [15:0] lo, input logic [15:0] hi);
        logic [15:0] src;
        case (p)
            2'd0:    src = t;
            2'd1:    src = {c, c};
            2'd2:    src = lo;
            default: src = hi;
        endcase
        return idx ? src[7:0] : src[15:8];
    endfunction

    // Config reads never advance past byte 0; 16-bit reads alternate MSB/LSB.
    assign nextIdx  = (ptr == 2'd1) ? 2'd0 : {1'b0, ~byteIdx[0]};
    assign curByte  = rdByte(ptr, byteIdx[0], tempSnap, configReg, tLowReg, tHighReg);
    assign msbByte  = rdByte(ptr, 1'b0,       tempSnap, configReg, tLowReg, tHighReg);
    assign nextByte = rdByte(ptr, nextIdx[0], tempSnap, configReg, tLowReg, tHighReg);

    always_comb begin
        stateNxt  = state;
        shNxt     = shReg;
        cntNxt    = bitCnt;
        idxNxt    = byteIdx;
        ptrNxt    = ptr;
        snapNxt   = tempSnap;
        stageNxt  = stage;
        cfgNxt    = configReg;
        tLowNxt   = tLowReg;
        tHighNxt  = tHighReg;
        sdaLowNxt = sdaLow;
        selNxt    = selReg;
        strobeNxt = 1'b0;

        if (startCond) begin
            stateNxt  = ADDR;
            cntNxt    = 4'd0;
            sdaLowNxt = 1'b0;
            selNxt    = 1'b0;
        end else if (stopCond) begin
            // A half-finished 16-bit write lives only in stage, so it is dropped here.
            stateNxt  = IDLE;
            sdaLowNxt = 1'b0;
            selNxt    = 1'b0;
            idxNxt    = 2'd0;
        end else begin
            if (sclRise && (state == ADDR || state == PTR || state == WDATA)) begin
                shNxt  = {shReg[6:0], sdaS2};
                cntNxt = bitCnt + 4'd1;
            end
            if (sclRise && state == RDATA)
                cntNxt = bitCnt + 4'd1;

            // All SDA changes happen on a synchronized SCL fall.
            case (state)
                ADDR: if (sclFall && bitCnt == 4'd8) begin
                    if (shReg[7:1] == SLAVE_ADDR) begin
                        stateNxt  = ADDR_ACK;
                        sdaLowNxt = 1'b1;
                        selNxt    = 1'b1;
                        if (shReg[0]) snapNxt = {TempIn, 4'b0000};
                    end else begin
                        stateNxt = IGNORE;
                    end
                end
                // shReg still holds the address byte, so shReg[0] is R/W.
                ADDR_ACK: if (sclFall) begin
                    cntNxt = 4'd0;
                    idxNxt = 2'd0;
                    if (shReg[0]) begin
                        stateNxt  = RDATA;
                        sdaLowNxt = ~msbByte[7];
                    end else begin
                        stateNxt  = PTR;
                        sdaLowNxt = 1'b0;
                    end
                end
                PTR: if (sclFall && bitCnt == 4'd8) begin
                    ptrNxt    = shReg[1:0];
                    idxNxt    = 2'd0;
                    sdaLowNxt = 1'b1;
                    stateNxt  = PTR_ACK;
                end
                PTR_ACK, WDATA_ACK: if (sclFall) begin
                    sdaLowNxt = 1'b0;
                    cntNxt    = 4'd0;
                    stateNxt  = WDATA;
                end
                WDATA: if (sclFall && bitCnt == 4'd8) begin
                    stateNxt  = WDATA_ACK;
                    sdaLowNxt = 1'b1;
                    idxNxt    = byteIdx + 2'd1;
                    // NACK writes to the read-only temperature or past register width.
                    if (ptr == 2'd0 || (ptr == 2'd1 && byteIdx != 2'd0) || byteIdx == 2'd2) begin
                        stateNxt  = IGNORE;
                        sdaLowNxt = 1'b0;
                        idxNxt    = byteIdx;
                    end else if (ptr == 2'd1) begin
                        cfgNxt    = shReg;
                        strobeNxt = 1'b1;
                    end else if (byteIdx == 2'd0) begin
                        stageNxt  = shReg;
                    end else begin
                        strobeNxt = 1'b1;
                        if (ptr == 2'd2) tLowNxt  = {stage, shReg};
                        else             tHighNxt = {stage, shReg};
                    end
                end
                RDATA: if (sclFall) begin
                    if (bitCnt == 4'd8) begin
                        sdaLowNxt = 1'b0;
                        stateNxt  = RD_ACK;
                    end else begin
                        sdaLowNxt = ~curByte[3'd7 - bitCnt[2:0]];
                    end
                end
                RD_ACK: begin
                    if (sclRise && sdaS2) begin
                        stateNxt = IGNORE;
                        selNxt   = 1'b0;
                    end else if (sclFall) begin
                        idxNxt    = nextIdx;
                        cntNxt    = 4'd0;
                        sdaLowNxt = ~nextByte[7];
                        stateNxt  = RDATA;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            // Synchronizers start at the idle-bus level so reset makes no false edge.
            sclS1     <= 1'b1;
            sclS2     <= 1'b1;
            sclPrev   <= 1'b1;
            sdaS1     <= 1'b1;
            sdaS2     <= 1'b1;
            sdaPrev   <= 1'b1;
            state     <= IDLE;
            shReg     <= 8'h00;
            bitCnt    <= 4'd0;
            byteIdx   <= 2'd0;
            ptr       <= 2'd0;
            tempSnap  <= 16'h0000;
            stage     <= 8'h00;
            configReg <= 8'h00;
            tLowReg   <= TLOW_RESET;
            tHighReg  <= THIGH_RESET;
            sdaLow    <= 1'b0;
            selReg    <= 1'b0;
            strobe    <= 1'b0;
        end else begin
            sclS1     <= SCL;
            sclS2     <= sclS1;
            sclPrev   <= sclS2;
            sdaS1     <= SDA;
            sdaS2     <= sdaS1;
            sdaPrev   <= sdaS2;
            state     <= stateNxt;
            shReg     <= shNxt;
            bitCnt    <= cntNxt;
            byteIdx   <= idxNxt;
            ptr       <= ptrNxt;
            tempSnap  <= snapNxt;
            stage     <= stageNxt;
            configReg <= cfgNxt;
            tLowReg   <= tLowNxt;
            tHighReg  <= tHighNxt;
            sdaLow    <= sdaLowNxt;
            selReg    <= selNxt;
            strobe    <= strobeNxt;
        end
    end

    assign ConfigOut   = configReg;
    assign TLowOut     = tLowReg;
    assign THighOut    = tHighReg;
    assign Selected    = selReg;
    assign WriteStrobe = strobe;

endmodule

// File: tb/tb_i2c_target_responder.sv
// Directed bench for i2c_target_responder: a bit-banged master drives SCL/SDA
// on the falling system-clock edge and checks ACKs, read data and registers.
module tb_i2c_target_responder;

    logic        clock = 1'b0;
    logic        Reset = 1'b0;
    logic        SCL   = 1'b1;
    logic        mLow  = 1'b0;
    logic [11:0] TempIn = 12'h000;
    wire         SDA;
    logic [7:0]  ConfigOut;
    logic [15:0] TLowOut, THighOut;
    logic        Selected, WriteStrobe;

    assign SDA = mLow ? 1'b0 : 1'bz;
    pullup (SDA);

    i2c_target_responder dut (
        .clock(clock), .Reset(Reset), .SCL(SCL), .SDA(SDA), .TempIn(TempIn),
        .ConfigOut(ConfigOut), .TLowOut(TLowOut), .THighOut(THighOut),
        .Selected(Selected), .WriteStrobe(WriteStrobe)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int strobeCnt = 0;
    int driveCnt = 0;
    int selCnt = 0;

    // Activity monitors, sampled 1 time unit after the active edge.
    always begin
        @(posedge clock);
        #1;
        if (WriteStrobe) strobeCnt = strobeCnt + 1;
        if (SDA === 1'b0 && !mLow) driveCnt = driveCnt + 1;
        if (Selected) selCnt = selCnt + 1;
    end

    task automatic wclk(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic mStart();
        mLow = 1'b0; wclk(5);
        SCL  = 1'b1; wclk(6);
        mLow = 1'b1; wclk(6);
        SCL  = 1'b0; wclk(4);
    endtask

    task automatic mStop();
        mLow = 1'b1; wclk(5);
        SCL  = 1'b1; wclk(6);
        mLow = 1'b0; wclk(6);
    endtask

    task automatic mBit(input logic b);
        mLow = ~b; wclk(5);
        SCL  = 1'b1; wclk(6);
        SCL  = 1'b0; wclk(4);
    endtask

    task automatic mReadBit(output logic b);
        mLow = 1'b0; wclk(5);
        SCL  = 1'b1; wclk(3);
        b    = (SDA === 1'b0) ? 1'b0 : 1'b1;
        wclk(3);
        SCL  = 1'b0; wclk(4);
    endtask

    // ack returns 1 when the target pulled SDA low on the 9th clock.
    task automatic mWriteByte(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) mBit(d[i]);
        mReadBit(b);
        ack = ~b;
    endtask

    task automatic mReadByte(output logic [7:0] d, input logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            mReadBit(b);
            d[i] = b;
        end
        mBit(~ack);
    endtask

    task automatic test_reset();
        Reset = 1'b0; wclk(3);
        checks++; if (SDA !== 1'b1) begin errors++; $display("FAIL reset_sda got %b exp 1", SDA); end
        checks++; if (ConfigOut !== 8'h00) begin errors++; $display("FAIL reset_cfg got %h exp 00", ConfigOut); end
        checks++; if (TLowOut !== 16'h4B00) begin errors++; $display("FAIL reset_tlow got %h exp 4b00", TLowOut); end
        checks++; if (THighOut !== 16'h5000) begin errors++; $display("FAIL reset_thigh got %h exp 5000", THighOut); end
        checks++; if (Selected !== 1'b0) begin errors++; $display("FAIL reset_sel got %b exp 0", Selected); end
        checks++; if (WriteStrobe !== 1'b0) begin errors++; $display("FAIL reset_strobe got %b exp 0", WriteStrobe); end
        Reset = 1'b1; wclk(4);
    endtask

    task automatic test_config_write();
        logic [2:0] acks;
        logic selMid;
        int base = strobeCnt;
        mStart();
        mWriteByte(8'h90, acks[2]);
        selMid = Selected;
        mWriteByte(8'h01, acks[1]);
        mWriteByte(8'h60, acks[0]);
        mStop();
        checks++; if (acks !== 3'b111) begin errors++; $display("FAIL cfg_acks got %b exp 111", acks); end
        checks++; if (selMid !== 1'b1) begin errors++; $display("FAIL cfg_selected got %b exp 1", selMid); end
        checks++; if (ConfigOut !== 8'h60) begin errors++; $display("FAIL cfg_value got %h exp 60", ConfigOut); end
        checks++; if (strobeCnt - base !== 1) begin errors++; $display("FAIL cfg_strobes got %0d exp 1", strobeCnt - base); end
        checks++; if (Selected !== 1'b0) begin errors++; $display("FAIL cfg_sel_after_stop got %b exp 0", Selected); end
    endtask

    task automatic test_temp_read();
        logic [2:0] acks;
        logic [7:0] d1, d2;
        TempIn = 12'h190;
        mStart();
        mWriteByte(8'h90, acks[2]);
        mWriteByte(8'h00, acks[1]);
        mStart();
        mWriteByte(8'h91, acks[0]);
        mReadByte(d1, 1'b1);
        TempIn = 12'h7FF;
        mReadByte(d2, 1'b0);
        checks++; if (Selected !== 1'b0) begin errors++; $display("FAIL temp_sel_after_nack got %b exp 0", Selected); end
        mStop();
        checks++; if (acks !== 3'b111) begin errors++; $display("FAIL temp_acks got %b exp 111", acks); end
        checks++; if (d1 !== 8'h19) begin errors++; $display("FAIL temp_msb got %h exp 19", d1); end
        checks++; if (d2 !== 8'h00) begin errors++; $display("FAIL temp_lsb got %h exp 00", d2); end
    endtask

    task automatic test_thigh_rw();
        logic [4:0] acks;
        logic [7:0] d1, d2, d3;
        int base = strobeCnt;
        mStart();
        mWriteByte(8'h90, acks[4]);
        mWriteByte(8'h03, acks[3]);
        mWriteByte(8'h12, acks[2]);
        mWriteByte(8'h34, acks[1]);
        mStop();
        checks++; if (THighOut !== 16'h1234) begin errors++; $display("FAIL thigh_value got %h exp 1234", THighOut); end
        checks++; if (strobeCnt - base !== 1) begin errors++; $display("FAIL thigh_strobes got %0d exp 1", strobeCnt - base); end
        mStart();
        mWriteByte(8'h91, acks[0]);
        mReadByte(d1, 1'b1);
        mReadByte(d2, 1'b1);
        mReadByte(d3, 1'b0);
        mStop();
        checks++; if (acks !== 5'b11111) begin errors++; $display("FAIL thigh_acks got %b exp 11111", acks); end
        checks++; if ({d1, d2, d3} !== 24'h123412) begin errors++; $display("FAIL thigh_read got %h exp 123412", {d1, d2, d3}); end
    endtask

    task automatic test_mismatch();
        logic ack;
        int sBase = strobeCnt, dBase = driveCnt, selBase = selCnt;
        mStart();
        mWriteByte(8'h92, ack);
        mWriteByte(8'h01, ack);
        mStop();
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL mis_ack got %b exp 0", ack); end
        checks++; if (driveCnt - dBase !== 0) begin errors++; $display("FAIL mis_sda_driven got %0d exp 0", driveCnt - dBase); end
        checks++; if (selCnt - selBase !== 0) begin errors++; $display("FAIL mis_selected got %0d exp 0", selCnt - selBase); end
        checks++; if ({ConfigOut, THighOut} !== 24'h601234) begin errors++; $display("FAIL mis_regs got %h exp 601234", {ConfigOut, THighOut}); end
        checks++; if (strobeCnt - sBase !== 0) begin errors++; $display("FAIL mis_strobes got %0d exp 0", strobeCnt - sBase); end
    endtask

    task automatic test_write_nacks();
        logic [6:0] acks;
        int base = strobeCnt;
        mStart();
        mWriteByte(8'h90, acks[6]);
        mWriteByte(8'h00, acks[5]);
        mWriteByte(8'h55, acks[4]);
        mStop();
        mStart();
        mWriteByte(8'h90, acks[3]);
        mWriteByte(8'h01, acks[2]);
        mWriteByte(8'hA5, acks[1]);
        mWriteByte(8'h5A, acks[0]);
        mStop();
        checks++; if (acks !== 7'b1101110) begin errors++; $display("FAIL nack_acks got %b exp 1101110", acks); end
        checks++; if (ConfigOut !== 8'hA5) begin errors++; $display("FAIL nack_cfg got %h exp a5", ConfigOut); end
        checks++; if (strobeCnt - base !== 1) begin errors++; $display("FAIL nack_strobes got %0d exp 1", strobeCnt - base); end
    endtask

    task automatic test_partial_write();
        logic [2:0] acks;
        int base = strobeCnt;
        mStart();
        mWriteByte(8'h90, acks[2]);
        mWriteByte(8'h02, acks[1]);
        mWriteByte(8'hAB, acks[0]);
        mStop();
        checks++; if (acks !== 3'b111) begin errors++; $display("FAIL part_acks got %b exp 111", acks); end
        checks++; if (TLowOut !== 16'h4B00) begin errors++; $display("FAIL part_tlow got %h exp 4b00", TLowOut); end
        checks++; if (strobeCnt - base !== 0) begin errors++; $display("FAIL part_strobes got %0d exp 0", strobeCnt - base); end
    endtask

    // Pointer is 2 here, so the read starts with 0x4B whose MSB is 0 (SDA held low).
    task automatic test_reset_midread();
        logic ack;
        mStart();
        mWriteByte(8'h91, ack);
        mLow = 1'b0; wclk(2);
        checks++; if (SDA !== 1'b0) begin errors++; $display("FAIL rst_pre_sda got %b exp 0", SDA); end
        Reset = 1'b0;
        #1;
        checks++; if (SDA !== 1'b1) begin errors++; $display("FAIL rst_sda_release got %b exp 1", SDA); end
        checks++; if ({ConfigOut, TLowOut, THighOut, Selected, WriteStrobe} !== {8'h00, 16'h4B00, 16'h5000, 2'b00})
            begin errors++; $display("FAIL rst_outputs got %h %h %h %b %b exp 00 4b00 5000 0 0", ConfigOut, TLowOut, THighOut, Selected, WriteStrobe); end
        wclk(3);
        Reset = 1'b1; wclk(4);
        mStart();
        mWriteByte(8'h90, ack);
        mStop();
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL rst_next_ack got %b exp 1", ack); end
    endtask

    initial begin
        test_reset();
        test_config_write();
        test_temp_read();
        test_thigh_rw();
        test_mismatch();
        test_write_nacks();
        test_partial_write();
        test_reset_midread();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_target_responder.md
# i2c_target_responder

Synthesizable I2C target (slave) that answers the team's I2C master data unit at the far end of the SDA/SCL bus. It models a TMP101-style register map (pointer, temperature, configuration, TLOW, THIGH) so the master driver can be exercised in simulation and on the board without the physical sensor. The block oversamples SCL/SDA on the system clock, detects START/STOP, decodes address and R/W, ACKs, and shifts register bytes in or out on an open-drain SDA.

## Interface
- SLAVE_ADDR, 7'b1001000, 7-bit target address matched after START
- TLOW_RESET, 16'h4B00, reset value of TLOW register
- THIGH_RESET, 16'h5000, reset value of THIGH register
- clock  input  1  system clock, at least 8x SCL frequency
- Reset  input  1  reset; one clock, reset is asynchronous and active-low
- SCL  input  1  bus clock from master, asynchronous to clock
- SDA  inout  1  open-drain data; block drives only 1'b0 or 1'bz
- TempIn  input  12  live temperature code, two's complement
- ConfigOut  output  8  configuration register
- TLowOut  output  16  TLOW register
- THighOut  output  16  THIGH register
- Selected  output  1  high from address-match ACK until STOP, repeated START, or master NACK
- WriteStrobe  output  1  one-cycle pulse when a register is updated

## Operation
- SCL and SDA each pass through identical 2-flop synchronizers plus one history flop; edges are detected on the synchronized values.
- START: SDA falls while SCL high. STOP: SDA rises while SCL high. Both are honoured in every state and take priority over bit handling.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RD_ACK, IGNORE.
- IDLE/IGNORE -> ADDR on START. ADDR shifts 8 bits MSB first on SCL rise; on match -> ADDR_ACK, otherwise -> IGNORE with SDA released.
- ADDR_ACK: drives 0 for the 9th clock. R/W=0 -> PTR. R/W=1 -> RDATA; temperature is snapshotted as {TempIn,4'b0} at this point.
- PTR: bits [1:0] of received byte become pointer (0 temp, 1 config, 2 TLOW, 3 THIGH); bits [7:2] ignored; always ACKed -> WDATA.
- WDATA: 16-bit regs take MSB then LSB. MSB goes to a staging register; register updates with WriteStrobe at LSB ACK. Config updates at its first data byte ACK. Pointer 0 (read-only) and bytes beyond register width are NACKed (SDA released), -> IGNORE.
- RDATA: shifts register MSB byte then LSB byte (config: single byte), bit 7 first, driving 0 for data 0 and releasing for data 1. Byte index wraps back to MSB after last byte.
- RD_ACK: samples master bit on 9th SCL rise. ACK (0) -> next byte. NACK -> IGNORE, Selected drops.
- Repeated START -> ADDR, pointer retained. STOP -> IDLE, SDA released, pointer retained, incomplete 16-bit write discarded.

## Timing
- Reset values: SDA released (z), ConfigOut 8'h00, TLowOut TLOW_RESET, THighOut THIGH_RESET, pointer 2'b00, Selected 0, WriteStrobe 0, state IDLE.
- Data sampled 1 clock after synchronized SCL rise; synchronizer latency 2 clocks.
- SDA output changes only in the cycle after a synchronized SCL fall; it is never changed while synchronized SCL is high. The block therefore cannot create false START/STOP.
- ACK is driven from the SCL fall after bit 8 until the SCL fall after bit 9.
- Master constraints: SCL high and low phases at least 4 clocks; SDA stable at least 3 clocks before SCL rise.
- WriteStrobe and register update occur in the same cycle as the ACK drive begins.
- Asynchronous Reset mid-transfer releases SDA immediately. The next transfer starts from IDLE and waits for START.

## Test plan
- Write 0x90, 0x01, 0x60, STOP -> three ACKs, ConfigOut=8'h60, one WriteStrobe pulse.
- TempIn=12'h190; write 0x90,0x00, repeated START, 0x91, read 2 bytes ACK/NACK -> bytes 0x19, 0x00; TempIn changed mid-read does not alter byte 2.
- Write 0x90,0x03,0x12,0x34 then read back -> THighOut=16'h1234, read returns 0x12,0x34, third ACKed read returns 0x12.
- Address 0x92 (mismatch) -> no ACK, SDA never driven, registers unchanged, Selected stays 0.
- Write 0x90,0x02,0xAB then STOP -> TLowOut stays 16'h4B00, no WriteStrobe.
- Assert Reset during RDATA with SDA driven low -> SDA released immediately, all outputs at reset values, next valid transfer ACKed.
